// File: rtl/mpadd_arbiter_pkg.sv
// Shared definitions for the word-serial multi-precision add/subtract engine:
// default geometry, FSM state encodings and client identifiers.
package mpadd_arbiter_pkg;

  localparam int WORD_DEF   = 64;
  localparam int NWORDS_DEF = 2;

  // Encodings stay as plain constants so legacy tooling can display them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  function automatic int cnt_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/mpadd_limb_datapath.sv
// Limb-serial adder datapath: operand shift registers, one WORD-bit adder
// with optional B inversion, carry register and result shift register.
module mpadd_limb_datapath
  import mpadd_arbiter_pkg::*;
#(
  parameter  int WORD   = WORD_DEF,
  parameter  int NWORDS = NWORDS_DEF,
  localparam int W      = WORD * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         first,
  input  logic         sub_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W:0]   result
);

  logic [W-1:0]      a_sr;
  logic [W-1:0]      b_sr;
  logic [W-1:0]      sum_sr;
  logic              sub_q;
  logic              carry_q;
  logic [WORD-1:0]   b_eff;
  logic              carry_in;
  logic [WORD:0]     limb_sum;
  logic [W+WORD-1:0] sum_cat;

  // NOTE: every signal driven from always_comb is assigned on all paths so
  // no latch can be inferred; here each one is a single unconditional assign.
  always_comb begin
    b_eff    = b_sr[WORD-1:0] ^ {WORD{sub_q}};
    // Subtraction is A + ~B + 1: the +1 enters as carry-in of the first limb.
    carry_in = first ? sub_q : carry_q;
    limb_sum = {1'b0, a_sr[WORD-1:0]} + {1'b0, b_eff} + {{WORD{1'b0}}, carry_in};
    sum_cat  = {limb_sum[WORD-1:0], sum_sr};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (load) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      sub_q <= sub_in;
    end else if (shift) begin
      a_sr    <= a_sr >> WORD;
      b_sr    <= b_sr >> WORD;
      sum_sr  <= sum_cat[W+WORD-1:WORD];
      carry_q <= limb_sum[WORD];
    end
  end

  // Sum and carry are left untouched by a new load, so the previous result
  // stays visible until the first limb of the next operation is written.
  assign result = {carry_q, sum_sr};

endmodule

// File: rtl/mpadd_arbiter.sv
// Two-client round-robin front end for the shared limb-serial add/subtract
// datapath: FSM, limb counter, last-served pointer and done decode.
module mpadd_arbiter
  import mpadd_arbiter_pkg::*;
#(
  parameter  int WORD   = WORD_DEF,
  parameter  int NWORDS = NWORDS_DEF,
  localparam int W      = WORD * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         sub0,
  input  logic         sub1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [W:0]   result,
  output logic         done0,
  output logic         done1,
  output logic         busy
);

  localparam int CW = cnt_width(NWORDS);
  localparam logic [CW-1:0] LAST_LIMB = CW'(NWORDS - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          ptr;
  logic          gnt;
  logic          gnt_next;
  logic          load;
  logic          shift;
  logic          first;
  logic          sub_sel;
  logic [W-1:0]  a_sel;
  logic [W-1:0]  b_sel;

  always_comb begin
    // A tie goes to whichever client was not served last.
    gnt_next = (req0 && req1) ? ~ptr : (req1 ? CLIENT1 : CLIENT0);
    load     = (state == ST_IDLE) && (req0 || req1);
    shift    = (state == ST_RUN);
    first    = (cnt == '0);
    sub_sel  = (gnt_next == CLIENT1) ? sub1 : sub0;
    a_sel    = (gnt_next == CLIENT1) ? a1   : a0;
    b_sel    = (gnt_next == CLIENT1) ? b1   : b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= CLIENT1;
      gnt   <= CLIENT0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state <= ST_RUN;
            cnt   <= '0;
            ptr   <= gnt_next;
            gnt   <= gnt_next;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_LIMB) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state != ST_IDLE);
  assign done0 = (state == ST_DONE) && (gnt == CLIENT0);
  assign done1 = (state == ST_DONE) && (gnt == CLIENT1);

  mpadd_limb_datapath #(
    .WORD   (WORD),
    .NWORDS (NWORDS)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .first  (first),
    .sub_in (sub_sel),
    .a_in   (a_sel),
    .b_in   (b_sel),
    .result (result)
  );

endmodule
